// File: rtl/hex_page_sched.sv
// hex_page_sched: round-robin page scheduler that shares one two-digit hex display among byte slots
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   wr_en_i      write strobe; stores wr_data_i into slot wr_slot_i and marks it valid
//   wr_slot_i    slot index for the write
//   wr_data_i    byte to store
//   clr_en_i     clear strobe; invalidates slot clr_slot_i (data kept)
//   clr_slot_i   slot index for the clear
//   hold_i       freeze rotation (dwell counter and pointer)
//   hex_val_o    byte currently shown, 00 when nothing is valid
//   cur_slot_o   index of the slot currently shown
//   cur_valid_o  1 when cur_slot_o holds valid data
module hex_page_sched #(
  parameter int NUM_SLOTS = 4,
  parameter int DWELL     = 12_000_000,
  parameter int CNT_W     = 24,
  parameter bit PREEMPT   = 1'b0,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [SLOT_W-1:0] wr_slot_i,
  input  logic [7:0]        wr_data_i,
  input  logic              clr_en_i,
  input  logic [SLOT_W-1:0] clr_slot_i,
  input  logic              hold_i,
  output logic [7:0]        hex_val_o,
  output logic [SLOT_W-1:0] cur_slot_o,
  output logic              cur_valid_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);
  logic [7:0]           data_q [NUM_SLOTS];
  logic [7:0]           data_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [SLOT_W-1:0]    cur_slot_q, cur_slot_d, nxt_slot, idx;
  logic                 cur_valid_q, cur_valid_d, found;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Clear is applied before write so a same-slot write wins.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_en_i) valid_d[clr_slot_i] = 1'b0;
    if (wr_en_i) begin
      valid_d[wr_slot_i] = 1'b1;
      data_d[wr_slot_i]  = wr_data_i;
    end
  end
  // First valid slot after the current one, wrapping back to the current slot itself.
  // NUM_SLOTS is a power of two, so index addition wraps naturally.
  always_comb begin
    nxt_slot = cur_slot_q;
    found    = 1'b0;
    idx      = cur_slot_q;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      idx = cur_slot_q + SLOT_W'(k);
      if (!found && valid_d[idx]) begin
        nxt_slot = idx;
        found    = 1'b1;
      end
    end
  end
  always_comb begin
    cur_slot_d = cur_slot_q;
    cnt_d      = cnt_q;
    if (PREEMPT && wr_en_i) begin
      cur_slot_d = wr_slot_i;
      cnt_d      = '0;
    end else if (valid_d == '0) begin
      cnt_d = '0;
    end else if (!cur_valid_q || !valid_d[cur_slot_q]) begin
      // Shown slot vanished or nothing was shown: move on even while held.
      cur_slot_d = nxt_slot;
      cnt_d      = '0;
    end else if (!hold_i) begin
      cur_slot_d = (cnt_q == LAST) ? nxt_slot : cur_slot_q;
      cnt_d      = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    cur_valid_d = valid_d[cur_slot_d];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q      <= '{default: '0};
      valid_q     <= '0;
      cur_slot_q  <= '0;
      cur_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      cur_slot_q  <= cur_slot_d;
      cur_valid_q <= cur_valid_d;
      cnt_q       <= cnt_d;
    end
  end
  assign hex_val_o   = cur_valid_q ? data_q[cur_slot_q] : 8'h00;
  assign cur_slot_o  = cur_slot_q;
  assign cur_valid_o = cur_valid_q;
endmodule

// File: tb/tb_hex_page_sched.sv
// tb_hex_page_sched: randomized and directed checks of hex_page_sched against a behavioural model
module tb_hex_page_sched;
  localparam int DW = 4;
  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, clr_en = 1'b0, hold = 1'b0;
  logic [1:0] wr_slot = '0, clr_slot = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] hex0, hex1;
  logic [1:0] cs0, cs1;
  logic       cv0, cv1;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] md [2][4];
  bit         mv [2][4];
  int         mcur [2];
  bit         mcv [2];
  int         mcnt [2];

  always #5 clk = ~clk;

  hex_page_sched #(.NUM_SLOTS(4), .DWELL(DW), .CNT_W(4), .PREEMPT(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_slot_i(wr_slot), .wr_data_i(wr_data),
    .clr_en_i(clr_en), .clr_slot_i(clr_slot), .hold_i(hold),
    .hex_val_o(hex0), .cur_slot_o(cs0), .cur_valid_o(cv0));

  hex_page_sched #(.NUM_SLOTS(4), .DWELL(DW), .CNT_W(4), .PREEMPT(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_slot_i(wr_slot), .wr_data_i(wr_data),
    .clr_en_i(clr_en), .clr_slot_i(clr_slot), .hold_i(hold),
    .hex_val_o(hex1), .cur_slot_o(cs1), .cur_valid_o(cv1));

  // Model m=0 mirrors the PREEMPT=0 instance, m=1 the PREEMPT=1 instance.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit vn [4];
      int nxt;
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) begin
          md[m][i] = 8'h00;
          mv[m][i] = 1'b0;
        end
        mcur[m] = 0;
        mcv[m]  = 1'b0;
        mcnt[m] = 0;
      end else begin
        vn = mv[m];
        if (clr_en) vn[clr_slot] = 1'b0;
        if (wr_en) begin
          vn[wr_slot] = 1'b1;
          md[m][wr_slot] = wr_data;
        end
        nxt = mcur[m];
        for (int k = 4; k >= 1; k--)
          if (vn[(mcur[m] + k) % 4]) nxt = (mcur[m] + k) % 4;
        if (m == 1 && wr_en) begin
          mcur[m] = int'(wr_slot);
          mcnt[m] = 0;
        end else if (!(vn[0] || vn[1] || vn[2] || vn[3])) begin
          mcnt[m] = 0;
        end else if (!mcv[m] || !vn[mcur[m]]) begin
          mcur[m] = nxt;
          mcnt[m] = 0;
        end else if (!hold) begin
          if (mcnt[m] == DW - 1) begin
            mcur[m] = nxt;
            mcnt[m] = 0;
          end else mcnt[m]++;
        end
        mv[m]  = vn;
        mcv[m] = vn[mcur[m]];
      end
    end
  endtask

  function automatic logic [10:0] exp_out(int m);
    return {mcv[m] ? md[m][mcur[m]] : 8'h00, 2'(mcur[m]), mcv[m]};
  endfunction

  function automatic logic [10:0] got(int m);
    return (m == 0) ? {hex0, cs0, cv0} : {hex1, cs1, cv1};
  endfunction

  function automatic int succ(int s);
    return (s == 0) ? 2 : (s == 2) ? 3 : 0;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b1;
    wr_slot = 2'($urandom);
    wr_data = 8'($urandom);
    repeat (3) step();
    wr_en = 1'b0;
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (got(m) !== 11'h000) begin
        n_bad++;
        $display("FAIL reset_hold dut%0d got %h exp %h", m, got(m), 11'h000);
      end
    end
    rst_n = 1'b1;
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (got(m) !== 11'h000) begin
        n_bad++;
        $display("FAIL reset_release dut%0d got %h exp %h", m, got(m), 11'h000);
      end
    end
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_slot = 2'(i);
      wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (got(m) !== 11'h000) begin
        n_bad++;
        $display("FAIL reset_mid dut%0d got %h exp %h", m, got(m), 11'h000);
      end
    end
  endtask

  task automatic test_single();
    wr_en = 1'b1;
    wr_slot = 2'd2;
    wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (got(m) !== {8'hA5, 2'd2, 1'b1}) begin
          n_bad++;
          $display("FAIL single_slot dut%0d cyc%0d got %h exp %h", m, c, got(m), {8'hA5, 2'd2, 1'b1});
        end
      end
      step();
    end
  endtask

  task automatic test_rotate();
    int prev, run;
    bit first;
    wr_en = 1'b1;
    wr_slot = 2'd0;
    wr_data = 8'h12;
    step();
    wr_slot = 2'd3;
    wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    prev = int'(cs0);
    run = 1;
    first = 1'b1;
    repeat (24) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (got(m) !== exp_out(m)) begin
          n_bad++;
          $display("FAIL rotate dut%0d got %h exp %h", m, got(m), exp_out(m));
        end
      end
      if (int'(cs0) == prev) run++;
      else begin
        if (!first) begin
          n_cmp++;
          if (run != DW) begin
            n_bad++;
            $display("FAIL rotate_dwell slot%0d got %0d exp %0d", prev, run, DW);
          end
        end
        n_cmp++;
        if (int'(cs0) != succ(prev)) begin
          n_bad++;
          $display("FAIL rotate_order got %0d exp %0d", cs0, succ(prev));
        end
        first = 1'b0;
        prev = int'(cs0);
        run = 1;
      end
    end
  endtask

  task automatic test_hold();
    int s, tries;
    tries = 0;
    while (mcnt[0] != 2 && tries < 16) begin
      step();
      tries++;
    end
    n_cmp++;
    if (mcnt[0] != 2) begin
      n_bad++;
      $display("FAIL hold_sync got cnt %0d exp %0d", mcnt[0], 2);
    end
    s = int'(cs0);
    hold = 1'b1;
    repeat (10) begin
      step();
      n_cmp++;
      if (got(0) !== exp_out(0) || int'(cs0) != s) begin
        n_bad++;
        $display("FAIL hold_freeze got %h exp %h", got(0), exp_out(0));
      end
    end
    hold = 1'b0;
    step();
    n_cmp++;
    if (int'(cs0) != s) begin
      n_bad++;
      $display("FAIL hold_resume got %0d exp %0d", cs0, s);
    end
    step();
    n_cmp++;
    if (int'(cs0) != succ(s) || got(0) !== exp_out(0)) begin
      n_bad++;
      $display("FAIL hold_advance got %h exp %h", got(0), exp_out(0));
    end
    hold = 1'b1;
    clr_en = 1'b1;
    clr_slot = cs0;
    s = int'(cs0);
    step();
    clr_en = 1'b0;
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (got(m) !== exp_out(m)) begin
        n_bad++;
        $display("FAIL hold_clear dut%0d got %h exp %h", m, got(m), exp_out(m));
      end
    end
    n_cmp++;
    if (int'(cs0) != succ(s)) begin
      n_bad++;
      $display("FAIL hold_clear_slot got %0d exp %0d", cs0, succ(s));
    end
    hold = 1'b0;
  endtask

  task automatic test_wr_clr();
    wr_en = 1'b1;
    clr_en = 1'b1;
    wr_slot = 2'd1;
    clr_slot = 2'd1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clr_slot = 2'(i);
      if (i != 1) step();
    end
    clr_en = 1'b0;
    repeat (2) step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (got(m) !== {8'h77, 2'd1, 1'b1} || got(m) !== exp_out(m)) begin
        n_bad++;
        $display("FAIL wr_clr_same dut%0d got %h exp %h", m, got(m), {8'h77, 2'd1, 1'b1});
      end
    end
    clr_en = 1'b1;
    clr_slot = 2'd1;
    step();
    clr_en = 1'b0;
    step();
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (got(m) !== {8'h00, 2'd1, 1'b0}) begin
        n_bad++;
        $display("FAIL clear_all dut%0d got %h exp %h", m, got(m), {8'h00, 2'd1, 1'b0});
      end
    end
  endtask

  task automatic test_preempt();
    int tries;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wr_en = 1'b1;
    wr_slot = 2'd0;
    wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    tries = 0;
    while (mcnt[1] != 2 && tries < 16) begin
      step();
      tries++;
    end
    n_cmp++;
    if (mcnt[1] != 2 || cs1 !== 2'd0) begin
      n_bad++;
      $display("FAIL preempt_sync got slot %0d cnt %0d exp slot 0 cnt 2", cs1, mcnt[1]);
    end
    hold = 1'b1;
    wr_en = 1'b1;
    wr_slot = 2'd1;
    wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (got(1) !== {8'hFF, 2'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL preempt_switch got %h exp %h", got(1), {8'hFF, 2'd1, 1'b1});
    end
    n_cmp++;
    if (got(0) !== {8'hAA, 2'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL preempt_off got %h exp %h", got(0), {8'hAA, 2'd0, 1'b1});
    end
    hold = 1'b0;
    repeat (12) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (got(m) !== exp_out(m)) begin
          n_bad++;
          $display("FAIL preempt_resume dut%0d got %h exp %h", m, got(m), exp_out(m));
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      rst_n = ($urandom_range(63) != 0);
      wr_en = ($urandom_range(3) == 0);
      wr_slot = 2'($urandom);
      wr_data = 8'($urandom);
      clr_en = ($urandom_range(4) == 0);
      clr_slot = 2'($urandom);
      hold = ($urandom_range(3) == 0);
      step();
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (got(m) !== exp_out(m)) begin
          n_bad++;
          $display("FAIL random dut%0d got %h exp %h", m, got(m), exp_out(m));
        end
      end
    end
    rst_n = 1'b1;
    wr_en = 1'b0;
    clr_en = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_rotate();
    test_hold();
    test_wr_clr();
    test_preempt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
